// File: rtl/delta_decoder_pkg.sv
// Shared types and constants for the delta decoder.
package delta_pkg;

  // Decoder mode: waiting for an anchoring keyframe, or summing deltas.
  typedef enum logic {
    WAIT_KEY = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam int DW_DEF      = 32;
  localparam int MAX_RUN_DEF = 256;

  // Signed rails for the default sample width.
  localparam logic [DW_DEF-1:0] SMAX = {1'b0, {(DW_DEF-1){1'b1}}};
  localparam logic [DW_DEF-1:0] SMIN = {1'b1, {(DW_DEF-1){1'b0}}};

endpackage

// File: rtl/delta_decoder_sat_add.sv
// Saturating signed adder: a + b clamped to the DW-bit two's complement range.
module sat_add #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] sum,
  output logic          sat
);

  localparam logic [DW-1:0] RAIL_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] RAIL_MIN = {1'b1, {(DW-1){1'b0}}};

  logic [DW:0] sum_ext;

  // Sign-extend to DW+1 bits; the two top bits disagree exactly on overflow.
  always_comb begin
    sum_ext = {a[DW-1], a} + {b[DW-1], b};
    sat     = sum_ext[DW] ^ sum_ext[DW-1];
    sum     = sum_ext[DW-1:0];
    if (sat) begin
      sum = sum_ext[DW] ? RAIL_MIN : RAIL_MAX;
    end
  end

endmodule

// File: rtl/delta_decoder.sv
// Rebuilds absolute samples from keyframes plus signed first differences.
// Single registered output stage with valid/ready on both sides.
module delta_decoder
  import delta_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int MAX_RUN = MAX_RUN_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_key,
  input  logic [DW-1:0]    s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_sample,
  output logic             m_sat,
  output logic             run_err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int            RW        = $clog2(MAX_RUN + 1);
  localparam logic [RW-1:0] RUN_LIMIT = RW'(MAX_RUN);

  state_t          state, state_nxt;
  logic [DW-1:0]   acc, acc_nxt;
  logic [RW-1:0]   run, run_nxt;
  logic            accept;
  logic            load;
  logic [DW-1:0]   load_data;
  logic            load_sat;
  logic            drop;
  logic            err;
  logic [DW-1:0]   sum;
  logic            sum_sat;

  // The output register may refill in the same cycle it drains.
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  sat_add #(.DW(DW)) u_sat_add (
    .a   (acc),
    .b   (s_data),
    .sum (sum),
    .sat (sum_sat)
  );

  // Next-state decode: keyframes re-anchor, deltas accumulate until the run limit.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    acc_nxt   = acc;
    run_nxt   = run;
    load      = 1'b0;
    load_data = '0;
    load_sat  = 1'b0;
    drop      = 1'b0;
    err       = 1'b0;
    if (accept) begin
      if (s_key) begin
        acc_nxt   = s_data;
        load      = 1'b1;
        load_data = s_data;
        run_nxt   = '0;
        state_nxt = RUN;
      end else begin
        unique case (state)
          WAIT_KEY: drop = 1'b1;
          RUN: begin
            if (run < RUN_LIMIT) begin
              acc_nxt   = sum;
              load      = 1'b1;
              load_data = sum;
              load_sat  = sum_sat;
              run_nxt   = run + RW'(1);
            end else begin
              drop      = 1'b1;
              err       = 1'b1;
              state_nxt = WAIT_KEY;
            end
          end
          default: state_nxt = WAIT_KEY;
        endcase
      end
    end
  end

  // State, accumulator, output register and drop counter.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      state    <= WAIT_KEY;
      acc      <= '0;
      run      <= '0;
      m_valid  <= 1'b0;
      m_sample <= '0;
      m_sat    <= 1'b0;
      run_err  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      run     <= run_nxt;
      run_err <= err;
      if (load) begin
        m_valid  <= 1'b1;
        m_sample <= load_data;
        m_sat    <= load_sat;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_delta_decoder.sv
// Directed bench for delta_decoder, built with a short run limit of 4.
module tb_delta_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_key = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_ready = 1'b1;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_sample;
  logic        m_sat;
  logic        run_err;
  logic [15:0] drop_cnt;

  int          tests = 0;
  int          fails = 0;
  int          err_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [32:0] obs_q[$];

  delta_decoder #(.DW(32), .MAX_RUN(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_key    (s_key),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_sample (m_sample),
    .m_sat    (m_sat),
    .run_err  (run_err),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every output transfer and every run_err cycle, away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) obs_q.push_back({m_sat, m_sample});
      if (run_err) err_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_key   = 1'b0;
    rst     = 1'b1;
    idle(2);
    rst     = 1'b0;
    err_cnt = 0;
    obs_q.delete();
  endtask

  // Present one word and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input bit key, input logic [31:0] d);
    bit done = 1'b0;
    s_valid = 1'b1;
    s_key   = key;
    s_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_key   = 1'b0;
    s_data  = '0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL send_timeout: s_ready stayed 0 for 100 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({m_valid, m_sample, m_sat, run_err, drop_cnt, s_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 16'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got v=%0b s=%h sat=%0b err=%0b drop=%0d rdy=%0b, required 0 0 0 0 0 1",
               m_valid, m_sample, m_sat, run_err, drop_cnt, s_ready);
    end
  endtask

  task automatic test_basic();
    logic [32:0] exp[$] = '{{1'b0, 32'd100}, {1'b0, 32'd105}, {1'b0, 32'd102}, {1'b0, 32'hFFFFFF9E}};
    obs_q.delete();
    m_ready = 1'b1;
    send(1'b1, 32'd100);
    tests++;
    if (m_valid !== 1'b1 || m_sample !== 32'd100) begin
      fails++;
      $display("FAIL basic_latency: got v=%0b s=%0d, required v=1 s=100", m_valid, m_sample);
    end
    send(1'b0, 32'd5);
    send(1'b0, 32'hFFFFFFFD);
    send(1'b0, 32'hFFFFFF38);
    idle(3);
    tests++;
    if (obs_q.size() !== exp.size()) begin
      fails++;
      $display("FAIL basic_count: got %0d outputs, required %0d", obs_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp[i]) begin
          fails++;
          $display("FAIL basic_out[%0d]: got %h, required %h", i, obs_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [32:0] exp[$] = '{{1'b0, 32'h7FFFFFF0}, {1'b1, 32'h7FFFFFFF}, {1'b0, 32'h7FFFFFFE},
                            {1'b0, 32'h80000005}, {1'b1, 32'h80000000}};
    obs_q.delete();
    m_ready = 1'b1;
    send(1'b1, 32'h7FFFFFF0);
    send(1'b0, 32'h00000020);
    send(1'b0, 32'hFFFFFFFF);
    send(1'b1, 32'h80000005);
    send(1'b0, 32'hFFFFFFF0);
    idle(3);
    tests++;
    if (obs_q.size() !== exp.size()) begin
      fails++;
      $display("FAIL sat_count: got %0d outputs, required %0d", obs_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp[i]) begin
          fails++;
          $display("FAIL sat_out[%0d]: got %h, required %h", i, obs_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_wait_key();
    logic [32:0] exp[$] = '{{1'b0, 32'd50}, {1'b0, 32'd51}};
    do_reset();
    m_ready = 1'b1;
    send(1'b0, 32'd7);
    send(1'b0, 32'd9);
    send(1'b1, 32'd50);
    send(1'b0, 32'd1);
    idle(3);
    tests++;
    if (drop_cnt !== 16'd2) begin
      fails++;
      $display("FAIL waitkey_drop_cnt: got %0d, required 2", drop_cnt);
    end
    tests++;
    if (obs_q.size() !== exp.size()) begin
      fails++;
      $display("FAIL waitkey_count: got %0d outputs, required %0d", obs_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp[i]) begin
          fails++;
          $display("FAIL waitkey_out[%0d]: got %h, required %h", i, obs_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_run_limit();
    logic [32:0] exp[$] = '{{1'b0, 32'd10}, {1'b0, 32'd11}, {1'b0, 32'd12}, {1'b0, 32'd13},
                            {1'b0, 32'd14}, {1'b0, 32'd0}};
    do_reset();
    m_ready = 1'b1;
    send(1'b1, 32'd10);
    for (int i = 0; i < 4; i++) send(1'b0, 32'd1);
    send(1'b0, 32'd1);
    tests++;
    if (run_err !== 1'b1) begin
      fails++;
      $display("FAIL runlimit_err_pulse: got %0b, required 1", run_err);
    end
    idle(2);
    tests++;
    if (err_cnt !== 1) begin
      fails++;
      $display("FAIL runlimit_err_cycles: got %0d, required 1", err_cnt);
    end
    tests++;
    if (drop_cnt !== 16'd1) begin
      fails++;
      $display("FAIL runlimit_drop1: got %0d, required 1", drop_cnt);
    end
    send(1'b0, 32'd1);
    idle(1);
    tests++;
    if (drop_cnt !== 16'd2) begin
      fails++;
      $display("FAIL runlimit_drop2: got %0d, required 2", drop_cnt);
    end
    send(1'b1, 32'd0);
    idle(3);
    tests++;
    if (obs_q.size() !== exp.size()) begin
      fails++;
      $display("FAIL runlimit_count: got %0d outputs, required %0d", obs_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp[i]) begin
          fails++;
          $display("FAIL runlimit_out[%0d]: got %h, required %h", i, obs_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp[$] = '{{1'b0, 32'd1000}, {1'b0, 32'd1005}};
    longint      acc_m = 0;
    int          run_m = 0;
    bit          first = 1'b1;
    int          shown = 0;
    do_reset();
    m_ready = 1'b1;
    send(1'b1, 32'd1000);
    // Hold the output for three cycles with a delta waiting.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_key   = 1'b0;
    s_data  = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_sample !== 32'd1000) begin
        fails++;
        $display("FAIL hold_cycle%0d: got rdy=%0b v=%0b s=%0d, required 0 1 1000", i, s_ready, m_valid, m_sample);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_release: got s_ready=%0b, required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    idle(2);
    // Random downstream stalls over 1000 deltas against a saturating reference sum.
    rand_ready = 1'b1;
    for (int n = 0; n < 1000; ) begin
      if (first || run_m == 4 || $urandom_range(0, 9) == 0) begin
        logic [31:0] k = $urandom();
        first = 1'b0;
        send(1'b1, k);
        exp.push_back({1'b0, k});
        acc_m = longint'($signed(k));
        run_m = 0;
      end else begin
        int     ds = int'($urandom()) >>> 1;
        longint s  = acc_m + longint'(ds);
        bit     st = 1'b0;
        if (s > 64'sd2147483647) begin
          s = 64'sd2147483647; st = 1'b1;
        end else if (s < -64'sd2147483648) begin
          s = -64'sd2147483648; st = 1'b1;
        end
        send(1'b0, 32'(ds));
        exp.push_back({st, 32'(s)});
        acc_m = s;
        run_m++;
        n++;
      end
    end
    rand_ready = 1'b0;
    m_ready    = 1'b1;
    idle(3);
    tests++;
    if (obs_q.size() !== exp.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d outputs, required %0d", obs_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        tests++;
        if (obs_q[i] !== exp[i]) begin
          fails++;
          if (shown < 5) $display("FAIL b2b_out[%0d]: got %h, required %h", i, obs_q[i], exp[i]);
          shown++;
        end
      end
    end
    tests++;
    if (drop_cnt !== 16'd0 || err_cnt !== 0) begin
      fails++;
      $display("FAIL b2b_no_drops: got drop=%0d err=%0d, required 0 0", drop_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0;
    send(1'b1, 32'd1);
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_held: got m_valid=%0b, required 1", m_valid);
    end
    rst = 1'b1;
    idle(1);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_valid: got m_valid=%0b, required 0", m_valid);
    end
    rst = 1'b0;
    err_cnt = 0;
    obs_q.delete();
    m_ready = 1'b1;
    send(1'b0, 32'd3);
    send(1'b0, 32'd4);
    idle(2);
    tests++;
    if (drop_cnt !== 16'd2 || obs_q.size() !== 0) begin
      fails++;
      $display("FAIL rstmid_drops: got drop=%0d outputs=%0d, required 2 0", drop_cnt, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_wait_key();
    test_run_limit();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
